// File: rtl/qpsk_pkg.sv
// Shared definitions for the QPSK receive chain: I/Q field layout,
// reduction modes and the collapser state encoding.
package qpsk_pkg;

  // Field positions inside a packed {I, Q} word
  localparam int I_MSB = 31;
  localparam int I_LSB = 16;
  localparam int Q_MSB = 15;
  localparam int Q_LSB = 0;

  // Group reduction modes
  localparam int MODE_PICK = 0;
  localparam int MODE_AVG  = 1;

  // Collapser FSM: COLLECT while gathering a group, HOLD while a result is pending
  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_HOLD    = 1'b1
  } state_e;

endpackage

// File: rtl/iq_accumulator.sv
// One signed 16-bit lane accumulator. The result port already includes the
// sample currently presented, so the final sample of a group never needs an
// extra cycle before the averaged value is available.
module iq_accumulator #(
  parameter int SHIFT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clear,
  input  logic        i_load,
  input  logic        i_add,
  input  logic [15:0] i_sample,
  output logic [15:0] o_result
);

  localparam int AW = 16 + SHIFT;

  logic signed [AW-1:0] r_acc;
  logic signed [AW-1:0] w_sample_ext;
  logic signed [AW-1:0] w_sum;

  assign w_sample_ext = {{SHIFT{i_sample[15]}}, i_sample};
  assign w_sum        = r_acc + w_sample_ext;
  // Taking bits [AW-1:SHIFT] is an arithmetic shift right with floor rounding;
  // the slice is exactly 16 bits wide, which is the kept result.
  assign o_result     = w_sum[AW-1:SHIFT];

  // Accumulator register: clear wins over load, load wins over add
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
    end else if (i_load) begin
      r_acc <= w_sample_ext;
    end else if (i_add) begin
      r_acc <= w_sum;
    end
  end

endmodule

// File: rtl/sample_collapser.sv
// Collapses each group of N consecutive {I, Q} words into one word, either by
// picking a fixed phase or by averaging. A tlast inside a group discards the
// partial group so the next group starts aligned to the frame.
module sample_collapser
  import qpsk_pkg::*;
#(
  parameter int N     = 4,
  parameter int MODE  = 1,
  parameter int PHASE = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_tdata,
  input  logic        in_tvalid,
  input  logic        in_tlast,
  output logic        in_tready,
  output logic [31:0] out_tdata,
  output logic        out_tvalid,
  input  logic        out_tready,
  output logic [15:0] drop_cnt
);

  localparam int             CW        = $clog2(N);
  localparam logic [CW-1:0]  LAST_IDX  = CW'(N - 1);
  localparam logic [CW-1:0]  PHASE_IDX = CW'(PHASE);

  state_e        r_state;
  state_e        w_state_next;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_pick;
  logic [31:0]   r_out_data;
  logic [15:0]   r_drop_cnt;

  logic          w_acc_in;
  logic          w_acc_out;
  logic          w_at_last;
  logic          w_complete;
  logic          w_drop;
  logic          w_first;
  logic [31:0]   w_avg;
  logic [31:0]   w_pick_word;
  logic [31:0]   w_result;

  assign out_tvalid = (r_state == ST_HOLD);
  assign out_tdata  = r_out_data;
  assign drop_cnt   = r_drop_cnt;

  // Only the final sample of a group can be blocked; it is let through as
  // soon as the pending result is drained in the same cycle.
  assign w_at_last  = (r_cnt == LAST_IDX);
  assign in_tready  = !w_at_last || !out_tvalid || out_tready;

  assign w_acc_in   = in_tvalid && in_tready;
  assign w_acc_out  = out_tvalid && out_tready;
  assign w_complete = w_acc_in && w_at_last;
  assign w_drop     = w_acc_in && in_tlast && !w_at_last;
  assign w_first    = w_acc_in && (r_cnt == '0);

  // Lane 0 carries Q (low half), lane 1 carries I (high half)
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      iq_accumulator #(
        .SHIFT (CW)
      ) u_lane (
        .clk      (clk),
        .rst_n    (reset),
        .i_clear  (w_drop),
        .i_load   (w_first),
        .i_add    (w_acc_in && !w_first),
        .i_sample (in_tdata[gi*16 +: 16]),
        .o_result (w_avg[gi*16 +: 16])
      );
    end
  endgenerate

  // When the kept phase is the last one it is taken straight from the input
  assign w_pick_word = (PHASE == N - 1) ? in_tdata : r_pick;
  assign w_result    = (MODE == MODE_AVG) ? w_avg : w_pick_word;

  // Group position counter; tlast mid-group realigns it to the frame start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (w_complete || w_drop) begin
      r_cnt <= '0;
    end else if (w_acc_in) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_COLLECT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: a completing group always lands in HOLD, even while draining
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_COLLECT: begin
        if (w_complete) begin
          w_state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (w_complete) begin
          w_state_next = ST_HOLD;
        end else if (w_acc_out) begin
          w_state_next = ST_COLLECT;
        end
      end
      default: w_state_next = ST_COLLECT;
    endcase
  end

  // Latch the selected phase as it passes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pick <= '0;
    end else if (w_acc_in && (r_cnt == PHASE_IDX)) begin
      r_pick <= in_tdata;
    end
  end

  // Result register; only loads on completion, so it is stable while stalled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_data <= '0;
    end else if (w_complete) begin
      r_out_data <= w_result;
    end
  end

  // Count discarded partial groups, saturating
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_sample_collapser.sv
// Directed and randomized-stall checks for sample_collapser using three
// instances: average N=4, pick N=4 PHASE=2, and average N=8.
module tb_sample_collapser;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- instance A: N=4, average ----------------
  logic [31:0] a_tdata = '0;
  logic        a_tvalid = 1'b0, a_tlast = 1'b0, a_tready;
  logic [31:0] a_odata;
  logic        a_ovalid, a_oready = 1'b1;
  logic [15:0] a_drop;

  sample_collapser #(.N(4), .MODE(1), .PHASE(0)) u_avg (
    .clk(clk), .reset(rst_n),
    .in_tdata(a_tdata), .in_tvalid(a_tvalid), .in_tlast(a_tlast), .in_tready(a_tready),
    .out_tdata(a_odata), .out_tvalid(a_ovalid), .out_tready(a_oready), .drop_cnt(a_drop)
  );

  // ---------------- instance P: N=4, pick phase 2 ----------------
  logic [31:0] p_tdata = '0;
  logic        p_tvalid = 1'b0, p_tready;
  logic [31:0] p_odata;
  logic        p_ovalid, p_oready = 1'b1;
  logic [15:0] p_drop;

  sample_collapser #(.N(4), .MODE(0), .PHASE(2)) u_pick (
    .clk(clk), .reset(rst_n),
    .in_tdata(p_tdata), .in_tvalid(p_tvalid), .in_tlast(1'b0), .in_tready(p_tready),
    .out_tdata(p_odata), .out_tvalid(p_ovalid), .out_tready(p_oready), .drop_cnt(p_drop)
  );

  // ---------------- instance R: N=8, average, random stalls ----------------
  logic [31:0] r_tdata = '0;
  logic        r_tvalid = 1'b0, r_tlast = 1'b0, r_tready;
  logic [31:0] r_odata;
  logic        r_ovalid, r_oready = 1'b1;
  logic [15:0] r_drop;

  sample_collapser #(.N(8), .MODE(1), .PHASE(0)) u_rnd (
    .clk(clk), .reset(rst_n),
    .in_tdata(r_tdata), .in_tvalid(r_tvalid), .in_tlast(r_tlast), .in_tready(r_tready),
    .out_tdata(r_odata), .out_tvalid(r_ovalid), .out_tready(r_oready), .drop_cnt(r_drop)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end else begin
      $display("ok   %s: %08h", tag, got);
    end
  endtask

  // ---------------- monitors (sample at negedge, away from the active edge) ----------------
  logic [31:0] a_outs[$];
  int          a_stamp[$];
  int          a_nin = 0;
  logic [31:0] p_outs[$];
  logic [31:0] r_exp[$];
  int          r_nout = 0;
  int          m_cnt = 0, m_sum_i = 0, m_sum_q = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (a_ovalid && a_oready) begin
        a_outs.push_back(a_odata);
        a_stamp.push_back(cyc);
      end
      if (a_tvalid && a_tready) a_nin++;
      if (p_ovalid && p_oready) p_outs.push_back(p_odata);
      if (r_ovalid && r_oready) begin
        r_nout++;
        check_eq("rnd_pending", {31'b0, r_exp.size() != 0}, 32'd1);
        if (r_exp.size() != 0) check_eq("rnd_data", r_odata, r_exp.pop_front());
      end
      // Reference: sum of 8 signed lanes, floor-divided by 8
      if (r_tvalid && r_tready) begin
        m_sum_i += int'($signed(r_tdata[31:16]));
        m_sum_q += int'($signed(r_tdata[15:0]));
        m_cnt++;
        if (m_cnt == 8) begin
          r_exp.push_back({16'(m_sum_i >>> 3), 16'(m_sum_q >>> 3)});
          m_cnt = 0; m_sum_i = 0; m_sum_q = 0;
        end
      end
    end
  end

  function automatic logic [31:0] get_a(input int idx);
    if (idx < a_outs.size()) return a_outs[idx];
    return 32'hDEADBEEF;
  endfunction

  function automatic int get_stamp(input int idx);
    if (idx < a_stamp.size()) return a_stamp[idx];
    return -1000;
  endfunction

  // Present one word to instance A and hold it until accepted (bounded)
  task automatic send_a(input logic [31:0] d, input logic l);
    logic done;
    int   n;
    a_tdata = d; a_tlast = l; a_tvalid = 1'b1;
    done = 1'b0; n = 0;
    while (!done && n < 50) begin
      @(negedge clk); done = a_tready;
      @(posedge clk); #1; n++;
    end
    check_eq("send_a_accepted", {31'b0, done}, 32'd1);
    a_tlast = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  logic [31:0] bp_words[12] = '{
    32'h00010000, 32'h00020000, 32'h00030000, 32'h00040000,   // -> 00020000
    32'hFFFF0007, 32'hFFFF0007, 32'hFFFF0007, 32'hFFFF0006,   // -> FFFF0006
    32'h0064FFF8, 32'h0064FFF8, 32'h0064FFF8, 32'h0064FFF8    // -> 0064FFF8
  };
  logic [31:0] pk_words[8] = '{32'hA, 32'hB, 32'hC, 32'hD, 32'hE, 32'hF, 32'h10, 32'h11};
  logic [31:0] t1_words[4] = '{32'h0004FFFF, 32'h0008FFFE, 32'h000CFFFD, 32'h0010FFFC};
  logic [31:0] rs_words[4] = '{32'h00020000, 32'h00040000, 32'h00060000, 32'h00080004};

  logic stream_done = 1'b0;
  logic bp_bad;
  int   base, nin0, n, sent;
  logic acc;

  initial begin
    // ---------------- reset ----------------
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_in_tready", {31'b0, a_tready}, 32'd1);
    check_eq("rst_out_tvalid", {31'b0, a_ovalid}, 32'd0);
    check_eq("rst_out_tdata", a_odata, 32'h0);
    check_eq("rst_drop_cnt", {16'b0, a_drop}, 32'h0);
    @(posedge clk); #1;

    // ---------------- average, N=4 ----------------
    a_oready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_a(t1_words[i], 1'b0);
      if (i == 2) check_eq("avg_no_early_valid", {31'b0, a_ovalid}, 32'd0);
    end
    a_tvalid = 1'b0;
    check_eq("avg_valid_latency", {31'b0, a_ovalid}, 32'd1);
    check_eq("avg_result", a_odata, {16'd10, 16'hFFFD});
    idle(2);
    check_eq("avg_drained", {31'b0, a_ovalid}, 32'd0);

    // ---------------- pick phase 2 ----------------
    for (int i = 0; i < 8; i++) begin
      p_tdata = pk_words[i]; p_tvalid = 1'b1;
      @(posedge clk); #1;
    end
    p_tvalid = 1'b0;
    idle(3);
    check_eq("pick_count", p_outs.size(), 32'd2);
    check_eq("pick_out0", (p_outs.size() > 0) ? p_outs[0] : 32'hDEADBEEF, 32'hC);
    check_eq("pick_out1", (p_outs.size() > 1) ? p_outs[1] : 32'hDEADBEEF, 32'h10);

    // ---------------- backpressure ----------------
    base = a_outs.size();
    nin0 = a_nin;
    a_oready = 1'b0;
    bp_bad = 1'b0;
    fork
      begin
        for (int i = 0; i < 12; i++) send_a(bp_words[i], 1'b0);
        a_tvalid = 1'b0;
        stream_done = 1'b1;
      end
    join_none
    repeat (10) begin
      @(negedge clk);
      if (a_ovalid && a_odata !== 32'h00020000) bp_bad = 1'b1;
    end
    check_eq("bp_data_stable", {31'b0, bp_bad}, 32'd0);
    check_eq("bp_accepted", a_nin - nin0, 32'd7);
    check_eq("bp_in_stalled", {31'b0, a_tready}, 32'd0);
    check_eq("bp_holding", {31'b0, a_ovalid}, 32'd1);
    @(posedge clk); #1;
    a_oready = 1'b1;
    n = 0;
    while (!stream_done && n < 200) begin @(posedge clk); #1; n++; end
    check_eq("bp_stream_done", {31'b0, stream_done}, 32'd1);
    idle(3);
    check_eq("bp_out_count", a_outs.size() - base, 32'd3);
    check_eq("bp_out0", get_a(base), 32'h00020000);
    check_eq("bp_out1", get_a(base + 1), 32'hFFFF0006);
    check_eq("bp_out2", get_a(base + 2), 32'h0064FFF8);
    check_eq("bp_gap01", get_stamp(base + 1) - get_stamp(base), 32'd1);
    check_eq("bp_gap12", get_stamp(base + 2) - get_stamp(base + 1), 32'd4);

    // ---------------- tlast mid-group ----------------
    base = a_outs.size();
    send_a(32'h00110011, 1'b0);
    send_a(32'h00220022, 1'b1);
    for (int i = 0; i < 4; i++) send_a(32'h00050005, 1'b0);
    a_tvalid = 1'b0;
    idle(3);
    check_eq("drop_cnt", {16'b0, a_drop}, 32'd1);
    check_eq("drop_out_count", a_outs.size() - base, 32'd1);
    check_eq("drop_out", get_a(base), 32'h00050005);

    // ---------------- reset mid-group ----------------
    send_a(32'h01000100, 1'b0);
    send_a(32'h01000100, 1'b0);
    a_tvalid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_in_tready", {31'b0, a_tready}, 32'd1);
    check_eq("mid_rst_out_tvalid", {31'b0, a_ovalid}, 32'd0);
    check_eq("mid_rst_out_tdata", a_odata, 32'h0);
    check_eq("mid_rst_drop_cnt", {16'b0, a_drop}, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    base = a_outs.size();
    for (int i = 0; i < 4; i++) send_a(rs_words[i], 1'b0);
    a_tvalid = 1'b0;
    idle(3);
    check_eq("post_rst_count", a_outs.size() - base, 32'd1);
    check_eq("post_rst_out", get_a(base), 32'h00050001);

    // ---------------- random valid/ready, N=8 ----------------
    sent = 0; n = 0;
    while (sent < 80 && n < 3000) begin
      @(negedge clk); acc = r_tvalid && r_tready;
      @(posedge clk); #1; n++;
      if (acc) begin sent++; r_tvalid = 1'b0; end
      if (!r_tvalid && sent < 80 && $urandom_range(3) != 0) begin
        r_tvalid = 1'b1;
        r_tdata  = $urandom;
        r_tlast  = (sent % 8 == 7);
      end
      r_oready = ($urandom_range(3) != 0);
    end
    r_tvalid = 1'b0;
    r_oready = 1'b1;
    n = 0;
    while ((r_exp.size() != 0 || r_ovalid) && n < 50) begin @(posedge clk); #1; n++; end
    check_eq("rnd_sent", sent, 32'd80);
    check_eq("rnd_out_count", r_nout, 32'd10);
    check_eq("rnd_model_empty", r_exp.size(), 32'd0);
    check_eq("rnd_drop_cnt", {16'b0, r_drop}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sample_collapser.md
# sample_collapser

- Receive-side counterpart of the N-times word repeater: it consumes groups of N consecutive 32-bit I/Q words and emits one word per group.
- The group is reduced either by picking one phase or by averaging I and Q.
- Sits after the matched filter / symbol-rate stage in the QPSK receive chain and feeds the 32-bit-to-2-bit symbol slicer.
- Recovers one symbol per N samples and realigns on frame boundaries.

## Interface
Parameters:
- N, 4, group length; power of two, 2..16.
- MODE, 1, 0 = pick the sample at index PHASE, 1 = average of the N samples.
- PHASE, 0, sample index kept when MODE = 0; range 0..N-1.

Ports:
- clk  in  1  single clock; all logic is in this domain.
- reset  in  1  asynchronous, active-low reset.
- in_tdata  in  32  {I[31:16], Q[15:0]}, two's complement.
- in_tvalid  in  1  input word valid.
- in_tlast  in  1  frame boundary marker, qualified by the input handshake.
- in_tready  out  1  input ready.
- out_tdata  out  32  {I, Q} result.
- out_tvalid  out  1  result valid.
- out_tready  in  1  downstream ready.
- drop_cnt  out  16  number of partial groups discarded; saturates at 16'hFFFF.

## Operation
- Input handshake `acc_in = in_tvalid && in_tready`; output handshake `acc_out = out_tvalid && out_tready`.
- Group counter `cnt`, width $clog2(N):
  - increments on each acc_in;
  - wraps from N-1 to 0 when a group completes.
- State machine, two states, reset state COLLECT:
  - COLLECT: accumulates; no result pending. Moves to HOLD when the group completes.
  - HOLD: out_tvalid = 1, result pending. Moves back to COLLECT on acc_out, unless a new group completes in the same cycle, in which case it stays in HOLD and the new result replaces the old.
- in_tready = (cnt != N-1) || !out_tvalid || out_tready.
  - This path is combinational from out_tready.
  - Non-final samples are always accepted. A final sample stalls only while the pending result is not being drained.
- MODE 1 (average):
  - I and Q accumulators are signed, 16+$clog2(N) bits each, sign-extended on add.
  - The first sample of a group loads the accumulators instead of adding to them.
  - Result = accumulator >>> $clog2(N): arithmetic shift, floor rounding, low 16 bits kept. No overflow is possible.
- MODE 0 (pick): the sample with index PHASE is latched. Result = the latched word, or in_tdata directly when PHASE = N-1.
- in_tlast accepted with cnt == N-1: the group completes normally and cnt returns to 0.
- in_tlast accepted with cnt < N-1:
  - the partial group, including this sample, is discarded;
  - cnt is forced to 0 and the accumulators are cleared;
  - drop_cnt increments, saturating;
  - no output is produced.
- in_tvalid deasserted mid-group: cnt and the accumulators hold; there is no timeout.

## Timing
- Reset values:
  - in_tready = 1 once reset is released, since cnt = 0;
  - out_tvalid = 0, out_tdata = 0, drop_cnt = 0;
  - cnt = 0, accumulators = 0, state COLLECT.
- Asserting reset mid-group or mid-HOLD discards the partial group and any pending result immediately.
- Latency: out_tvalid rises the cycle after the acc_in of the Nth sample.
- Sustained throughput: one input per cycle and one output per N cycles, with no bubbles while out_tready = 1.
- out_tdata is stable while out_tvalid = 1 && !out_tready.
- Simultaneous acc_out and group completion: the new result is registered and out_tvalid stays 1.
- N = 2: completing back-to-back groups sustains one output every 2 cycles.

## Structure
- Shared package `qpsk_pkg`:
  - IQ field positions (I_MSB = 31, I_LSB = 16, Q_MSB = 15, Q_LSB = 0);
  - MODE_PICK = 0, MODE_AVG = 1;
  - state encoding constants.
- Natural sub-module: `iq_accumulator`, holding one signed lane with load, add, clear and shift-out.
  - Instantiate it twice, once for I and once for Q.
- The FSM, counter, ready logic and drop counter stay in the top module.

## Test plan
- N = 4, MODE 1, out_tready = 1, inputs I = {4, 8, 12, 16} with Q = {-1, -2, -3, -4}:
  - out_tdata = {16'd10, 16'hFFFD} (Q = -3, floor of -2.5), one cycle after the 4th accept.
- N = 4, MODE 0, PHASE = 2, inputs 32'hA, B, C, D, then E, F, 10, 11:
  - outputs 32'hC then 32'h10; exactly 2 outputs.
- out_tready held at 0 for 10 cycles with a continuous input stream:
  - 3 samples of group 2 are accepted;
  - the 4th stalls with in_tready = 0;
  - out_tdata is stable throughout;
  - on release, group 1 is delivered and the stream then runs gap-free.
- in_tlast on the 2nd sample of a group, followed by 4 samples of value 32'h00050005 in MODE 1:
  - drop_cnt = 1;
  - a single output of 32'h00050005.
- Reset asserted after 2 samples of a group:
  - all outputs return to their reset values;
  - the next 4 samples produce exactly one correctly aligned output.
- Random valid/ready stall patterns with N = 8 against a reference model:
  - every output matches the model;
  - drop_cnt remains 0.
